// File: rtl/axi4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_pkg
// Description : Shared AXI4 encodings, FSM state types and width defaults.
// Revision    : 1.0
// ============================================================================
package axi4_pkg;

  localparam int DATA_BYTES_DEF     = 4;
  localparam int ADDR_BYTES_DEF     = 1;
  localparam int NUM_ID_BITS_DEF    = 4;
  localparam int NUM_USER_BITS_DEF  = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axi4_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : axi4_burst_addr
// Description : Next-beat address generator for FIXED / INCR / WRAP bursts.
// Revision    : 1.0
// ============================================================================
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] step;
  logic [AW-1:0] aligned;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;
  logic          wrap_ok;

  always_comb begin
    step      = AW'(1) << size;
    aligned   = addr & ~(step - AW'(1));
    incr_addr = aligned + step;
    // Only the legal wrap lengths wrap; anything else degrades to INCR.
    wrap_ok   = (burst == BURST_WRAP) &&
                ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    wrap_mask = ((AW'(len[3:0]) + AW'(1)) << size) - AW'(1);
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if (wrap_ok) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      next_addr = incr_addr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi4_mem_slave
// Description : AXI4 memory slave with independent read and write channels.
// Revision    : 1.0
// ============================================================================
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int DATA_BYTES      = DATA_BYTES_DEF,
  parameter int ADDR_BYTES      = ADDR_BYTES_DEF,
  parameter int NUM_ID_BITS_P   = NUM_ID_BITS_DEF,
  parameter int NUM_USER_BITS_P = NUM_USER_BITS_DEF,
  localparam int AW = ADDR_BYTES * 8,
  localparam int DW = DATA_BYTES * 8
) (
  input  logic                       aclk,
  input  logic                       areset,
  // write address
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [AW-1:0]              awaddr,
  input  logic [2:0]                 awsize,
  input  logic [1:0]                 awburst,
  input  logic [7:0]                 awlen,
  input  logic [NUM_ID_BITS_P-1:0]   awid,
  input  logic [3:0]                 awcache,
  input  logic [2:0]                 awprot,
  input  logic                       awlock,
  input  logic [3:0]                 awregion,
  input  logic [3:0]                 awqos,
  input  logic [NUM_USER_BITS_P-1:0] awuser,
  // write data
  input  logic                       wvalid,
  output logic                       wready,
  input  logic                       wlast,
  input  logic [DW-1:0]              wdata,
  input  logic [DATA_BYTES-1:0]      wstrb,
  input  logic [NUM_USER_BITS_P-1:0] wuser,
  // write response
  output logic                       bwvalid,
  input  logic                       bwready,
  output logic [1:0]                 bresp,
  output logic [NUM_ID_BITS_P-1:0]   bid,
  output logic [NUM_USER_BITS_P-1:0] buser,
  // read address
  input  logic                       arvalid,
  output logic                       aready,
  input  logic [AW-1:0]              araddr,
  input  logic [2:0]                 arsize,
  input  logic [1:0]                 arburst,
  input  logic [7:0]                 arlen,
  input  logic [NUM_ID_BITS_P-1:0]   arid,
  input  logic [3:0]                 arcache,
  input  logic [2:0]                 arprot,
  input  logic                       arlock,
  input  logic [3:0]                 arregion,
  input  logic [3:0]                 arqos,
  input  logic [NUM_USER_BITS_P-1:0] aruser,
  // read data
  output logic                       rvalid,
  input  logic                       rready,
  output logic                       rlast,
  output logic [DW-1:0]              rdata,
  output logic [1:0]                 rresp,
  output logic [NUM_ID_BITS_P-1:0]   rid,
  output logic [NUM_USER_BITS_P-1:0] ruser
);

  localparam int         OFF      = $clog2(DATA_BYTES);
  localparam int         NWORDS   = 2 ** (AW - OFF);
  localparam logic [2:0] MAX_SIZE = 3'(OFF);

  logic unused_inputs;
  assign unused_inputs = ^{awcache, awprot, awlock, awregion, awqos, awuser, wuser,
                           arcache, arprot, arlock, arregion, arqos, aruser};

  // Holds both address readies low until the first edge after reset release.
  logic ready_en_q;

  wr_state_e                 wr_state_q, wr_state_d;
  logic [AW-1:0]             waddr_q, waddr_d, waddr_nxt;
  logic [7:0]                wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]                wsize_q, wsize_d;
  logic [1:0]                wburst_q, wburst_d;
  logic [NUM_ID_BITS_P-1:0]  wid_q, wid_d;
  logic                      werr_q, werr_d;

  rd_state_e                 rd_state_q, rd_state_d;
  logic [AW-1:0]             raddr_q, raddr_d, raddr_nxt;
  logic [7:0]                rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]                rsize_q, rsize_d;
  logic [1:0]                rburst_q, rburst_d;
  logic [NUM_ID_BITS_P-1:0]  rid_q, rid_d;

  logic [DW-1:0]             mem_q [NWORDS];
  logic [DW-1:0]             mem_d [NWORDS];

  axi4_burst_addr #(.AW(AW)) u_waddr (
    .addr      (waddr_q),
    .size      (wsize_q),
    .len       (wlen_q),
    .burst     (wburst_q),
    .next_addr (waddr_nxt)
  );

  axi4_burst_addr #(.AW(AW)) u_raddr (
    .addr      (raddr_q),
    .size      (rsize_q),
    .len       (rlen_q),
    .burst     (rburst_q),
    .next_addr (raddr_nxt)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wbeat_d    = wbeat_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    wid_d      = wid_q;
    werr_d     = werr_q;
    mem_d      = mem_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (ready_en_q && awvalid) begin
          waddr_d    = awaddr;
          wlen_d     = awlen;
          wsize_d    = awsize;
          wburst_d   = awburst;
          wid_d      = awid;
          wbeat_d    = 8'd0;
          werr_d     = (awsize > MAX_SIZE);
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          // Oversized beats are accepted but must leave memory untouched.
          for (int b = 0; b < DATA_BYTES; b++) begin
            if (wstrb[b] && (wsize_q <= MAX_SIZE)) begin
              mem_d[waddr_q[AW-1:OFF]][8*b +: 8] = wdata[8*b +: 8];
            end
          end
          waddr_d = waddr_nxt;
          wbeat_d = wbeat_q + 8'd1;
          if (wlast != (wbeat_q == wlen_q)) begin
            werr_d = 1'b1;
          end
          if (wbeat_q == wlen_q) begin
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bwready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rbeat_d    = rbeat_q;
    rsize_d    = rsize_q;
    rburst_d   = rburst_q;
    rid_d      = rid_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ready_en_q && arvalid) begin
          raddr_d    = araddr;
          rlen_d     = arlen;
          rsize_d    = arsize;
          rburst_d   = arburst;
          rid_d      = arid;
          rbeat_d    = 8'd0;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          raddr_d = raddr_nxt;
          rbeat_d = rbeat_q + 8'd1;
          if (rbeat_q == rlen_q) begin
            rd_state_d = R_IDLE;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ready_en_q <= 1'b0;
      wr_state_q <= W_IDLE;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wbeat_q    <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      wid_q      <= '0;
      werr_q     <= 1'b0;
      rd_state_q <= R_IDLE;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rbeat_q    <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
      rid_q      <= '0;
      for (int i = 0; i < NWORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ready_en_q <= 1'b1;
      wr_state_q <= wr_state_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wbeat_q    <= wbeat_d;
      wsize_q    <= wsize_d;
      wburst_q   <= wburst_d;
      wid_q      <= wid_d;
      werr_q     <= werr_d;
      rd_state_q <= rd_state_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rbeat_q    <= rbeat_d;
      rsize_q    <= rsize_d;
      rburst_q   <= rburst_d;
      rid_q      <= rid_d;
      mem_q      <= mem_d;
    end
  end

  assign awready = ready_en_q && (wr_state_q == W_IDLE);
  assign wready  = (wr_state_q == W_DATA);
  assign bwvalid = (wr_state_q == W_RESP);
  assign bresp   = (bwvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;
  assign bid     = wid_q;
  assign buser   = '0;

  // Read data comes straight from the array, so a same-cycle write is not visible yet.
  assign aready  = ready_en_q && (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_DATA);
  assign rlast   = rvalid && (rbeat_q == rlen_q);
  assign rresp   = (rvalid && (rsize_q > MAX_SIZE)) ? RESP_SLVERR : RESP_OKAY;
  assign rid     = rid_q;
  assign rdata   = rvalid ? mem_q[raddr_q[AW-1:OFF]] : '0;
  assign ruser   = '0;

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_mem_slave
// Description : Directed self-checking bench for axi4_mem_slave.
// Revision    : 1.0
// ============================================================================
module tb_axi4_mem_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic        awvalid, awready, awlock, wvalid, wready, wlast;
  logic [7:0]  awaddr, awlen, araddr, arlen;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awid, awcache, awregion, awqos, awuser, wuser, wstrb;
  logic [31:0] wdata, rdata;
  logic        bwvalid, bwready, arvalid, aready, arlock, rvalid, rready, rlast;
  logic [3:0]  bid, buser, arid, arcache, arregion, arqos, aruser, rid, ruser;

  logic [31:0] wbuf [16];
  logic [31:0] ebuf [16];

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi4_mem_slave dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .awburst(awburst), .awlen(awlen), .awid(awid), .awcache(awcache),
    .awprot(awprot), .awlock(awlock), .awregion(awregion), .awqos(awqos),
    .awuser(awuser),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .wstrb(wstrb), .wuser(wuser),
    .bwvalid(bwvalid), .bwready(bwready), .bresp(bresp), .bid(bid), .buser(buser),
    .arvalid(arvalid), .aready(aready), .araddr(araddr), .arsize(arsize),
    .arburst(arburst), .arlen(arlen), .arid(arid), .arcache(arcache),
    .arprot(arprot), .arlock(arlock), .arregion(arregion), .arqos(arqos),
    .aruser(aruser),
    .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
    .rresp(rresp), .rid(rid), .ruser(ruser)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic aw_hs(input logic [7:0] a, input logic [7:0] len, input logic [2:0] sz,
                       input logic [1:0] bt, input logic [3:0] id, input string tag);
    int n;
    @(negedge aclk);
    awvalid = 1'b1; awaddr = a; awlen = len; awsize = sz; awburst = bt; awid = id;
    n = 0;
    while (!awready && n < 20) begin @(negedge aclk); n++; end
    if (!awready) check({tag, "_aw_timeout"}, 32'd0, 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic wr_burst(input logic [7:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input logic [3:0] id, input logic [3:0] strb,
                          input int last_at, input logic [1:0] er, input string tag);
    int n;
    aw_hs(a, len, sz, bt, id, tag);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at);
      n = 0;
      while (!wready && n < 20) begin @(negedge aclk); n++; end
      if (!wready) check({tag, "_w_timeout"}, 32'd0, 32'd1);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check({tag, "_bvalid"}, bwvalid, 1);
    check({tag, "_bresp"}, bresp, er);
    check({tag, "_bid"}, bid, id);
    @(negedge aclk);
    check({tag, "_bvalid_drop"}, bwvalid, 0);
  endtask

  task automatic rd_burst(input logic [7:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input logic [3:0] id, input logic [1:0] er,
                          input string tag);
    int n;
    @(negedge aclk);
    arvalid = 1'b1; araddr = a; arlen = len; arsize = sz; arburst = bt; arid = id;
    n = 0;
    while (!aready && n < 20) begin @(negedge aclk); n++; end
    if (!aready) check({tag, "_ar_timeout"}, 32'd0, 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      check({tag, "_rvalid"}, rvalid, 1);
      check({tag, "_rdata"}, rdata, ebuf[i]);
      check({tag, "_rlast"}, rlast, (i == int'(len)));
      check({tag, "_rresp"}, rresp, er);
      check({tag, "_rid"}, rid, id);
      @(negedge aclk);
    end
    check({tag, "_rvalid_drop"}, rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset = 1'b1;
    awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awid = 0;
    awcache = 0; awprot = 0; awlock = 0; awregion = 0; awqos = 0; awuser = 0;
    wvalid = 0; wlast = 0; wdata = 0; wstrb = 0; wuser = 0;
    bwready = 1'b1; rready = 1'b1;
    arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arid = 0;
    arcache = 0; arprot = 0; arlock = 0; arregion = 0; arqos = 0; aruser = 0;

    // Reset values
    repeat (3) @(negedge aclk);
    check("rst_awready", awready, 0);
    check("rst_aready", aready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bwvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("rel_awready", awready, 1);
    check("rel_aready", aready, 1);

    // Simultaneous AW/AR to 0xFC, W two cycles later
    awvalid = 1; awaddr = 8'hFC; awlen = 0; awsize = 2; awburst = 1; awid = 4'd3;
    arvalid = 1; araddr = 8'hFC; arlen = 0; arsize = 2; arburst = 1; arid = 4'd6;
    @(negedge aclk);
    awvalid = 0; arvalid = 0;
    check("same_rvalid", rvalid, 1);
    check("same_rdata", rdata, 32'h0);
    check("same_rlast", rlast, 1);
    check("same_rid", rid, 4'd6);
    @(negedge aclk);
    check("same_rdone", rvalid, 0);
    wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF; wlast = 1;
    @(negedge aclk);
    wvalid = 0; wlast = 0;
    check("same_bvalid", bwvalid, 1);
    check("same_bresp", bresp, 2'b00);
    check("same_bid", bid, 4'd3);
    ebuf[0] = 32'h12345678;
    rd_burst(8'hFC, 8'd0, 3'd2, 2'b01, 4'd1, 2'b00, "same_rb");

    // Single beat at 0xFF
    wbuf[0] = 32'hFFFFFFFF;
    wr_burst(8'hFF, 8'd0, 3'd2, 2'b01, 4'd5, 4'hF, 0, 2'b00, "ff_wr");
    ebuf[0] = 32'hFFFFFFFF;
    rd_burst(8'hFF, 8'd0, 3'd2, 2'b01, 4'd9, 2'b00, "ff_rd");

    // INCR wraps modulo the address space
    wbuf[0] = 32'h7; wbuf[1] = 32'h8;
    wr_burst(8'hFC, 8'd1, 3'd2, 2'b01, 4'd2, 4'hF, 1, 2'b00, "mod_wr");
    ebuf[0] = 32'h7; ebuf[1] = 32'h8;
    rd_burst(8'hFC, 8'd1, 3'd2, 2'b01, 4'd2, 2'b00, "mod_rd");

    // INCR len=3 at 0x10
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); ebuf[i] = 32'(i + 1); end
    wr_burst(8'h10, 8'd3, 3'd2, 2'b01, 4'd7, 4'hF, 3, 2'b00, "incr_wr");
    rd_burst(8'h10, 8'd3, 3'd2, 2'b01, 4'd8, 2'b00, "incr_rd");

    // WRAP len=3 at 0x38
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    wr_burst(8'h38, 8'd3, 3'd2, 2'b10, 4'd4, 4'hF, 3, 2'b00, "wrap_wr");
    ebuf[0] = 32'hC; ebuf[1] = 32'hD; ebuf[2] = 32'hA; ebuf[3] = 32'hB;
    rd_burst(8'h30, 8'd3, 3'd2, 2'b01, 4'd4, 2'b00, "wrap_lin");
    ebuf[0] = 32'hA; ebuf[1] = 32'hB; ebuf[2] = 32'hC; ebuf[3] = 32'hD;
    rd_burst(8'h38, 8'd3, 3'd2, 2'b10, 4'd4, 2'b00, "wrap_rd");

    // Byte strobes
    wbuf[0] = 32'hAABBCCDD;
    wr_burst(8'h20, 8'd0, 3'd2, 2'b01, 4'd1, 4'b0101, 0, 2'b00, "strb_wr");
    ebuf[0] = 32'h00BB00DD;
    rd_burst(8'h20, 8'd0, 3'd2, 2'b01, 4'd1, 2'b00, "strb_rd");

    // Oversized beats: SLVERR and no memory update
    wbuf[0] = 32'hFFFFFFFF;
    wr_burst(8'h40, 8'd0, 3'd3, 2'b01, 4'hE, 4'hF, 0, 2'b10, "big_wr");
    ebuf[0] = 32'h0;
    rd_burst(8'h40, 8'd0, 3'd2, 2'b01, 4'd2, 2'b00, "big_chk");
    rd_burst(8'h40, 8'd0, 3'd3, 2'b01, 4'd3, 2'b10, "big_rd");

    // Early wlast
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    wr_burst(8'h48, 8'd1, 3'd2, 2'b01, 4'd6, 4'hF, 0, 2'b10, "wlast_wr");

    // FIXED keeps the address
    wbuf[0] = 32'h5; wbuf[1] = 32'h6;
    wr_burst(8'h50, 8'd1, 3'd2, 2'b00, 4'd6, 4'hF, 1, 2'b00, "fix_wr");
    ebuf[0] = 32'h6;
    rd_burst(8'h50, 8'd0, 3'd2, 2'b01, 4'd6, 2'b00, "fix_rd");

    // WRAP with illegal length behaves as INCR
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33;
    wr_burst(8'h58, 8'd2, 3'd2, 2'b10, 4'd9, 4'hF, 2, 2'b00, "wrap3_wr");
    ebuf[0] = 32'h11; ebuf[1] = 32'h22; ebuf[2] = 32'h33;
    rd_burst(8'h58, 8'd2, 3'd2, 2'b01, 4'd9, 2'b00, "wrap3_rd");

    // Reset in the middle of a write burst
    aw_hs(8'h80, 8'd3, 3'd2, 2'b01, 4'hA, "mid");
    wvalid = 1; wdata = 32'h99; wstrb = 4'hF; wlast = 0;
    @(negedge aclk);
    check("mid_wready", wready, 1);
    areset = 1'b1;
    #1;
    wvalid = 0;
    check("mid_awready", awready, 0);
    check("mid_wready_rst", wready, 0);
    check("mid_aready", aready, 0);
    check("mid_bvalid", bwvalid, 0);
    check("mid_rvalid", rvalid, 0);
    repeat (2) @(negedge aclk);
    check("mid_bvalid_hold", bwvalid, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("mid_rel_awready", awready, 1);
    check("mid_rel_bvalid", bwvalid, 0);
    ebuf[0] = 32'h0;
    rd_burst(8'h80, 8'd0, 3'd2, 2'b01, 4'd1, 2'b00, "mid_rd80");
    rd_burst(8'h10, 8'd0, 3'd2, 2'b01, 4'd1, 2'b00, "mid_rd10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
